// File: rtl/rf_wb_sched_pkg.sv
// Shared sizing defaults and write-back source identifiers for the
// register-file write-back scheduler.
package rf_ctrl_pkg;

  localparam int RF_DATA_WIDTH  = 32;
  localparam int RF_REG_NUM     = 32;
  localparam int RF_REG_NUM_BIT = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_id_e;

endpackage

// File: rtl/rf_wb_sched_if.sv
// Issue, write-back and register-file write-port signals of the scheduler.
// The slave side is the scheduler; the master side is decode, units and bench.
interface rf_wb_sched_if
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int REG_NUM_BIT = RF_REG_NUM_BIT
) ();

  logic                   iss_valid;
  logic [REG_NUM_BIT-1:0] iss_rs1;
  logic [REG_NUM_BIT-1:0] iss_rs2;
  logic                   iss_rs1_en;
  logic                   iss_rs2_en;
  logic [REG_NUM_BIT-1:0] iss_rd;
  logic                   iss_rd_en;
  logic                   iss_ready;

  logic                   wb0_valid;
  logic [REG_NUM_BIT-1:0] wb0_addr;
  logic [DATA_WIDTH-1:0]  wb0_data;
  logic                   wb0_ready;
  logic                   wb1_valid;
  logic [REG_NUM_BIT-1:0] wb1_addr;
  logic [DATA_WIDTH-1:0]  wb1_data;
  logic                   wb1_ready;

  logic                   rf_wen;
  logic [REG_NUM_BIT-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]  rf_wdata;
  logic                   wb_err;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_rd_en,
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output iss_ready, wb0_ready, wb1_ready,
    output rf_wen, rf_waddr, rf_wdata, wb_err
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_rd_en,
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  iss_ready, wb0_ready, wb1_ready,
    input  rf_wen, rf_waddr, rf_wdata, wb_err
  );

endinterface

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-request round-robin arbiter; on contention the source that did not
// win most recently is granted.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_id_e last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == SRC_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to LSU so the ALU wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= SRC_LSU;
    end else if (|gnt) begin
      last <= gnt[1] ? SRC_LSU : SRC_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and scoreboard: arbitrates ALU/LSU results onto the
// single register-file write port and stalls issue on RAW/WAW hazards.
module rf_wb_sched
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int REG_NUM     = RF_REG_NUM,
  parameter int REG_NUM_BIT = RF_REG_NUM_BIT
) (
  input  logic         clk,
  input  logic         rst_n,
  rf_wb_sched_if.slave bus
);

  logic [REG_NUM-1:0]     busy;
  logic [REG_NUM-1:0]     busy_nxt;
  logic [1:0]             req;
  logic [1:0]             gnt;
  logic                   grant;
  src_id_e                sel;
  logic [REG_NUM_BIT-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   hazard;
  logic                   issue_fire;
  logic                   wen_q;
  logic [REG_NUM_BIT-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   err_q;

  always_comb begin
    hazard = (bus.iss_rs1_en & busy[bus.iss_rs1])
           | (bus.iss_rs2_en & busy[bus.iss_rs2])
           | (bus.iss_rd_en  & busy[bus.iss_rd]);
    issue_fire = bus.iss_valid & ~hazard & bus.iss_rd_en & (bus.iss_rd != '0);
  end

  assign bus.iss_ready = ~hazard;

  // Requests are masked during reset so sources never see a ready then.
  assign req = {bus.wb1_valid, bus.wb0_valid} & {2{rst_n}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.wb0_ready = gnt[0];
  assign bus.wb1_ready = gnt[1];

  always_comb begin
    grant   = |gnt;
    sel     = gnt[1] ? SRC_LSU : SRC_ALU;
    wb_addr = (sel == SRC_LSU) ? bus.wb1_addr : bus.wb0_addr;
    wb_data = (sel == SRC_LSU) ? bus.wb1_data : bus.wb0_data;
  end

  // The clear from a committing write and the set from a new issue never
  // hit the same register, since issue stalls while rd is busy.
  always_comb begin
    busy_nxt = busy;
    if (wen_q) begin
      busy_nxt[waddr_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[bus.iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Address/data hold their last granted value when nothing is accepted;
  // a write to x0 is accepted but never raises the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wen_q <= grant & (wb_addr != '0);
      if (grant) begin
        waddr_q <= wb_addr;
        wdata_q <= wb_data;
        if ((wb_addr != '0) && !busy[wb_addr]) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rf_wen   = wen_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.wb_err   = err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: a per-cycle vector table for hazards,
// latency and x0/error handling, then hand sequences for arbitration and reset.
module tb_rf_wb_sched;
  import rf_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rf_wb_sched_if bus ();

  rf_wb_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] iss_valid, rs1, rs1_en, rs2, rs2_en, rd, rd_en;
    logic [31:0] wb0_valid, wb0_addr, wb0_data;
    logic [31:0] wb1_valid, wb1_addr, wb1_data;
    logic [31:0] e_iss_ready, e_wb0_ready, e_wb1_ready, e_rf_wen, e_waddr, e_wdata, e_err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.iss_valid  = 1'b0;
    bus.iss_rs1    = '0;
    bus.iss_rs1_en = 1'b0;
    bus.iss_rs2    = '0;
    bus.iss_rs2_en = 1'b0;
    bus.iss_rd     = '0;
    bus.iss_rd_en  = 1'b0;
    bus.wb0_valid  = 1'b0;
    bus.wb0_addr   = '0;
    bus.wb0_data   = '0;
    bus.wb1_valid  = 1'b0;
    bus.wb1_addr   = '0;
    bus.wb1_data   = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.iss_valid  = v.iss_valid[0];
    bus.iss_rs1    = v.rs1[4:0];
    bus.iss_rs1_en = v.rs1_en[0];
    bus.iss_rs2    = v.rs2[4:0];
    bus.iss_rs2_en = v.rs2_en[0];
    bus.iss_rd     = v.rd[4:0];
    bus.iss_rd_en  = v.rd_en[0];
    bus.wb0_valid  = v.wb0_valid[0];
    bus.wb0_addr   = v.wb0_addr[4:0];
    bus.wb0_data   = v.wb0_data;
    bus.wb1_valid  = v.wb1_valid[0];
    bus.wb1_addr   = v.wb1_addr[4:0];
    bus.wb1_data   = v.wb1_data;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.iss_ready", i), 32'(bus.iss_ready), v.e_iss_ready);
    checkOutput($sformatf("v%0d.wb0_ready", i), 32'(bus.wb0_ready), v.e_wb0_ready);
    checkOutput($sformatf("v%0d.wb1_ready", i), 32'(bus.wb1_ready), v.e_wb1_ready);
    checkOutput($sformatf("v%0d.rf_wen", i),    32'(bus.rf_wen),    v.e_rf_wen);
    checkOutput($sformatf("v%0d.rf_waddr", i),  32'(bus.rf_waddr),  v.e_waddr);
    checkOutput($sformatf("v%0d.rf_wdata", i),  bus.rf_wdata,       v.e_wdata);
    checkOutput($sformatf("v%0d.wb_err", i),    32'(bus.wb_err),    v.e_err);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Field order: iss_valid rs1 rs1_en rs2 rs2_en rd rd_en | wb0 v/a/d | wb1 v/a/d |
    //              exp iss_ready wb0_ready wb1_ready rf_wen waddr wdata err
    vecs[0]  = '{0,0,0,0,0,0,0, 0,0,0,            0,0,0,       1,0,0,0,0,0,0};
    vecs[1]  = '{1,3,1,0,0,5,1, 0,0,0,            0,0,0,       1,0,0,0,0,0,0};
    vecs[2]  = '{1,5,1,0,0,6,1, 1,5,32'hDEADBEEF, 0,0,0,       0,1,0,0,0,0,0};
    vecs[3]  = '{1,5,1,0,0,6,1, 0,0,0,            0,0,0,       0,0,0,1,5,32'hDEADBEEF,0};
    vecs[4]  = '{1,5,1,0,0,6,1, 0,0,0,            0,0,0,       1,0,0,0,5,32'hDEADBEEF,0};
    vecs[5]  = '{1,0,0,0,0,6,1, 0,0,0,            1,6,32'h66,  0,0,1,0,5,32'hDEADBEEF,0};
    vecs[6]  = '{1,0,0,0,0,6,1, 0,0,0,            0,0,0,       0,0,0,1,6,32'h66,0};
    vecs[7]  = '{1,0,0,0,0,6,1, 0,0,0,            0,0,0,       1,0,0,0,6,32'h66,0};
    vecs[8]  = '{1,0,1,0,0,0,1, 0,0,0,            1,0,32'h1234, 1,0,1,0,6,32'h66,0};
    vecs[9]  = '{0,0,1,0,0,0,0, 0,0,0,            0,0,0,       1,0,0,0,0,32'h1234,0};
    vecs[10] = '{0,0,0,0,0,0,0, 1,9,32'h99,       0,0,0,       1,1,0,0,0,32'h1234,0};
    vecs[11] = '{0,0,0,0,0,0,0, 0,0,0,            0,0,0,       1,0,0,1,9,32'h99,1};
    vecs[12] = '{0,0,0,6,1,0,0, 0,0,0,            0,0,0,       0,0,0,0,9,32'h99,1};

    clearInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.rf_wen",   32'(bus.rf_wen),   32'd0);
    checkOutput("reset.rf_waddr", 32'(bus.rf_waddr), 32'd0);
    checkOutput("reset.rf_wdata", bus.rf_wdata,      32'd0);
    checkOutput("reset.wb_err",   32'(bus.wb_err),   32'd0);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    $display("[TB] contention after reset");
    clearInputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wb0_valid = 1'b1;
      bus.wb0_addr  = 5'd10;
      bus.wb0_data  = 32'(i);
      bus.wb1_valid = 1'b1;
      bus.wb1_addr  = 5'd11;
      bus.wb1_data  = 32'(100 + i);
      @(negedge clk);
      checkOutput($sformatf("cont%0d.wb0_ready", i), 32'(bus.wb0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont%0d.wb1_ready", i), 32'(bus.wb1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("cont%0d.rf_wen", i),   32'(bus.rf_wen),   32'd1);
      checkOutput($sformatf("cont%0d.rf_waddr", i), 32'(bus.rf_waddr), (i % 2 == 1) ? 32'd11 : 32'd10);
      checkOutput($sformatf("cont%0d.rf_wdata", i), bus.rf_wdata,      (i % 2 == 1) ? 32'(100 + i) : 32'(i));
    end

    bus.wb0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lone%0d.wb1_ready", i), 32'(bus.wb1_ready), 32'd1);
      checkOutput($sformatf("lone%0d.wb0_ready", i), 32'(bus.wb0_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("lone%0d.rf_waddr", i), 32'(bus.rf_waddr), 32'd11);
    end

    $display("[TB] reset mid-burst");
    bus.wb0_valid  = 1'b1;
    bus.iss_valid  = 1'b1;
    bus.iss_rd     = 5'd12;
    bus.iss_rd_en  = 1'b1;
    @(posedge clk);
    #1;
    bus.iss_valid  = 1'b0;
    bus.iss_rd_en  = 1'b0;
    bus.iss_rs1    = 5'd12;
    bus.iss_rs1_en = 1'b1;
    #1;
    checkOutput("burst.wb_err",    32'(bus.wb_err),    32'd1);
    checkOutput("burst.rf_wen",    32'(bus.rf_wen),    32'd1);
    checkOutput("burst.iss_ready", 32'(bus.iss_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.rf_wen",    32'(bus.rf_wen),    32'd0);
    checkOutput("rstmid.wb_err",    32'(bus.wb_err),    32'd0);
    checkOutput("rstmid.iss_ready", 32'(bus.iss_ready), 32'd1);
    checkOutput("rstmid.wb0_ready", 32'(bus.wb0_ready), 32'd0);
    checkOutput("rstmid.wb1_ready", 32'(bus.wb1_ready), 32'd0);
    checkOutput("rstmid.rf_waddr",  32'(bus.rf_waddr),  32'd0);

    clearInputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
